exe_stage_fwd: RTL and testbench
================================

// Module: exe_stage_fwd
// PURPOSE
//  EX stage of the ARM pipeline, directly downstream of the forwarding unit.
//  - Uses sel_src1/sel_src2 to pick each operand from ID/EX, WB result or MEM result.
//  - Executes the ALU command and maintains the NZCV status register.
//  - Registers results into the EX/MEM pipeline register (1-cycle latency).
// PARAMETERS
//  DATA_W   32  datapath width
//  REG_AW    4  register index width
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        asynchronous active-high reset
//  freeze         in   1        stall (SRAM wait): hold all state
//  val_rn         in   DATA_W   Rn value from ID/EX
//  val2_in        in   DATA_W   operand 2 from ID/EX (imm or shifted Rm)
//  val_rd         in   DATA_W   store-data register value from ID/EX
//  imm_in         in   1        1: val2_in is immediate, never forwarded
//  sel_src1       in   2        00 ID, 01 WB, 10 MEM, 11 = ID
//  sel_src2       in   2        same encoding, for op2 / store data
//  wb_value       in   DATA_W   WB-stage result
//  mem_alu_res    in   DATA_W   MEM-stage ALU result
//  exe_cmd        in   4        ALU command
//  s_in           in   1        update status when 1
//  dest_in        in   REG_AW   destination register
//  wb_en_in       in   1        ctrl: write back
//  mem_r_en_in    in   1        ctrl: load
//  mem_w_en_in    in   1        ctrl: store
//  alu_res_out    out  DATA_W   registered ALU result
//  st_val_out     out  DATA_W   registered store data
//  dest_out       out  REG_AW   registered destination register
//  wb_en_out      out  1        registered ctrl
//  mem_r_en_out   out  1        registered ctrl
//  mem_w_en_out   out  1        registered ctrl
//  status_out     out  4        NZCV {N,Z,C,V} to ID condition check
// BEHAVIOUR
//  - Reset (async, rst=1): all outputs and the status register clear to 0 immediately.
//    This includes during a freeze and mid-instruction.
//  - Operand A = mux(sel_src1: val_rn / wb_value / mem_alu_res).
//  - fwd2 = mux(sel_src2: val_rd / wb_value / mem_alu_res).
//  - Operand B = imm_in ? val2_in : (sel_src2==00 or 11 ? val2_in : fwd2).
//    A forwarded register operand is used unshifted.
//  - st_val = fwd2.
//  - exe_cmd: 0001 MOV B; 1001 MVN ~B; 0010 ADD A+B; 0011 ADC A+B+C;
//    0100 SUB/CMP A-B; 0101 SBC A-B-!C; 0110 AND/TST; 0111 ORR; 1000 EOR.
//    Any other command: result 0, flags unchanged.
//  - Arithmetic: 33-bit internal; C = bit32 for add.
//    For sub, C = NOT borrow (ARM convention): 5-3 gives C=1, 3-5 gives C=0.
//  - V is set on signed overflow for ADD/ADC/SUB/SBC only; logic ops and MOV keep the old C and V.
//  - N = res[31]; Z = (res==0).
//  - Status register loads new NZCV on a clk edge when s_in=1 and freeze=0; otherwise it holds.
//  - Pipeline register on clk edge:
//    - freeze=1: hold every output.
//    - freeze=0: load alu result, st_val, dest_in, wb_en_in, mem_r_en_in, mem_w_en_in.
//  - Latency: result visible 1 cycle after the operands are presented.
//  - Back-to-back dependent ops work via MEM forwarding; no bubbles are inserted here.
//  - Simultaneous freeze and s_in: freeze wins and the status is not updated.
// CONFIGURATION
//  STATUS_BYPASS_EN
//   - Defined: status_out = next NZCV combinationally whenever s_in=1 and freeze=0 this cycle.
//     The following instruction's condition check then sees the flags with zero delay.
//   - Undefined: status_out = registered NZCV only (one-cycle-late flags).
//     Upstream hazard logic must stall a dependent conditional instruction.
// TESTING
//  - rst pulse mid-cycle with freeze=1 -> all outputs and status_out = 0 without a clk edge.
//  - ADD val_rn=5, val2_in=3, sel=00/00, s_in=1 -> next edge alu_res_out=8, status 0000.
//  - sel_src1=10, mem_alu_res=0x10, val2_in=1, ADD -> alu_res_out=0x11.
//    Same with sel_src1=01, wb_value=0x20 -> 0x21.
//  - SUB A=3, B=5, s_in=1 -> result 0xFFFFFFFE, NZCV=1000.
//    Then SBC A=10, B=2 -> 7 (borrow applied).
//  - ADD 0x7FFFFFFF+1, s_in=1 -> NZCV=1001.
//    Then freeze=1 with a new SUB and s_in=1 -> outputs and status unchanged for every frozen cycle.
//  - STR path: mem_w_en_in=1, imm_in=1, sel_src2=01, wb_value=0xABCD.
//    -> st_val_out=0xABCD and alu_res_out uses val2_in (immediate not overridden).

Source files
------------

// File: rtl/exe_stage_fwd.sv
// -----------------------------------------------------------------------------
// exe_stage_fwd
//
// Execute stage of the ARM pipeline, placed directly after the forwarding unit.
// Picks each operand from ID/EX, the WB result or the MEM result, runs the ALU
// command, keeps the NZCV status register and registers everything into the
// EX/MEM pipeline register (one cycle of latency).
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   freeze          stall: every register holds its value
//   val_rn          Rn value from ID/EX
//   val2_in         operand 2 from ID/EX (immediate or shifted Rm)
//   val_rd          store-data register value from ID/EX
//   imm_in          val2_in is an immediate and is never forwarded
//   sel_src1/2      operand source select: 00 ID, 01 WB, 10 MEM, 11 ID
//   wb_value        WB-stage result
//   mem_alu_res     MEM-stage ALU result
//   exe_cmd         ALU command
//   s_in            update the status register
//   dest_in, wb_en_in, mem_r_en_in, mem_w_en_in   control passed down the pipe
//   alu_res_out, st_val_out, dest_out, wb_en_out,
//   mem_r_en_out, mem_w_en_out                    EX/MEM pipeline register
//   status_out      NZCV {N,Z,C,V} for the ID-stage condition check
//
// Configuration macro
//   STATUS_BYPASS_EN  when defined, status_out presents the next NZCV
//                     combinationally while a status update is pending this
//                     cycle; otherwise status_out is the registered NZCV only.
// -----------------------------------------------------------------------------
module exe_stage_fwd #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val2_in,
    input  logic [DATA_W-1:0] val_rd,
    input  logic              imm_in,
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] wb_value,
    input  logic [DATA_W-1:0] mem_alu_res,
    input  logic [3:0]        exe_cmd,
    input  logic              s_in,
    input  logic [REG_AW-1:0] dest_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] st_val_out,
    output logic [REG_AW-1:0] dest_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [3:0]        status_out
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] fwd2;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   wide;
    logic              c_new;
    logic              v_new;
    logic              cmd_valid;
    logic [3:0]        next_nzcv;
    logic [3:0]        status_reg;
    logic              carry;

    assign carry = status_reg[1];

    // Operand A comes from Rn, or is overridden by the WB or MEM result when
    // the forwarding unit detects a dependency. Code 11 is treated as "no
    // forwarding" so a glitchy select never picks an undefined source.
    always_comb begin
        op_a = val_rn;
        case (sel_src1)
            2'b01:   op_a = wb_value;
            2'b10:   op_a = mem_alu_res;
            default: op_a = val_rn;
        endcase
    end

    // The second forwarded value serves both the store data and, for
    // register operands, operand B. A forwarded register operand is used as
    // is (unshifted); an immediate must never be replaced by forwarded data,
    // which is why operand B checks imm_in first.
    always_comb begin
        fwd2 = val_rd;
        case (sel_src2)
            2'b01:   fwd2 = wb_value;
            2'b10:   fwd2 = mem_alu_res;
            default: fwd2 = val_rd;
        endcase
        if (imm_in || sel_src2 == 2'b00 || sel_src2 == 2'b11) begin
            op_b = val2_in;
        end else begin
            op_b = fwd2;
        end
    end

    // ALU. Arithmetic runs one bit wider so the carry/borrow falls out in the
    // top bit. For subtraction C is the inverted borrow (ARM convention).
    // Logic ops and moves keep the previous C and V. Unknown commands yield
    // zero and leave the flags untouched.
    always_comb begin
        alu_res   = '0;
        wide      = '0;
        c_new     = carry;
        v_new     = status_reg[0];
        cmd_valid = 1'b1;
        case (exe_cmd)
            CMD_MOV: alu_res = op_b;
            CMD_MVN: alu_res = ~op_b;
            CMD_ADD, CMD_ADC: begin
                wide    = {1'b0, op_a} + {1'b0, op_b}
                        + {{DATA_W{1'b0}}, (exe_cmd == CMD_ADC) & carry};
                alu_res = wide[DATA_W-1:0];
                c_new   = wide[DATA_W];
                v_new   = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            CMD_SUB, CMD_SBC: begin
                wide    = {1'b0, op_a} - {1'b0, op_b}
                        - {{DATA_W{1'b0}}, (exe_cmd == CMD_SBC) & ~carry};
                alu_res = wide[DATA_W-1:0];
                c_new   = ~wide[DATA_W];
                v_new   = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            CMD_AND: alu_res = op_a & op_b;
            CMD_ORR: alu_res = op_a | op_b;
            CMD_EOR: alu_res = op_a ^ op_b;
            default: cmd_valid = 1'b0;
        endcase
    end

    assign next_nzcv = cmd_valid ? {alu_res[DATA_W-1], (alu_res == '0), c_new, v_new}
                                 : status_reg;

    // Status register: only an unfrozen instruction with S set may change the
    // flags; a freeze always wins over s_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_reg <= 4'b0000;
        end else if (s_in && !freeze) begin
            status_reg <= next_nzcv;
        end
    end

    // EX/MEM pipeline register: loads every cycle unless the pipe is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_out  <= '0;
            st_val_out   <= '0;
            dest_out     <= '0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
        end else if (!freeze) begin
            alu_res_out  <= alu_res;
            st_val_out   <= fwd2;
            dest_out     <= dest_in;
            wb_en_out    <= wb_en_in;
            mem_r_en_out <= mem_r_en_in;
            mem_w_en_out <= mem_w_en_in;
        end
    end

`ifdef STATUS_BYPASS_EN
    // Bypass: the next instruction's condition check sees the new flags in
    // the same cycle they are being computed.
    assign status_out = (s_in && !freeze) ? next_nzcv : status_reg;
`else
    // Registered flags only; upstream hazard logic stalls dependents.
    assign status_out = status_reg;
`endif

endmodule

// File: tb/tb_exe_stage_fwd.sv
// -----------------------------------------------------------------------------
// tb_exe_stage_fwd
//
// Directed self-checking bench for exe_stage_fwd. Each task drives one
// scenario and compares the registered outputs against hand-computed values.
// Status is checked with s_in low so the value seen is the registered NZCV.
// -----------------------------------------------------------------------------
module tb_exe_stage_fwd;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic [31:0] val_rn;
    logic [31:0] val2_in;
    logic [31:0] val_rd;
    logic        imm_in;
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic [31:0] wb_value;
    logic [31:0] mem_alu_res;
    logic [3:0]  exe_cmd;
    logic        s_in;
    logic [3:0]  dest_in;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [31:0] alu_res_out;
    logic [31:0] st_val_out;
    logic [3:0]  dest_out;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic        mem_w_en_out;
    logic [3:0]  status_out;

    int checks = 0;
    int errors = 0;

    exe_stage_fwd #(.DATA_W(32), .REG_AW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .val_rn       (val_rn),
        .val2_in      (val2_in),
        .val_rd       (val_rd),
        .imm_in       (imm_in),
        .sel_src1     (sel_src1),
        .sel_src2     (sel_src2),
        .wb_value     (wb_value),
        .mem_alu_res  (mem_alu_res),
        .exe_cmd      (exe_cmd),
        .s_in         (s_in),
        .dest_in      (dest_in),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .alu_res_out  (alu_res_out),
        .st_val_out   (st_val_out),
        .dest_out     (dest_out),
        .wb_en_out    (wb_en_out),
        .mem_r_en_out (mem_r_en_out),
        .mem_w_en_out (mem_w_en_out),
        .status_out   (status_out)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a plain ID-sourced ALU operation.
    task automatic set_op(input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic s);
        exe_cmd     = cmd;
        val_rn      = a;
        val2_in     = b;
        s_in        = s;
        sel_src1    = 2'b00;
        sel_src2    = 2'b00;
        imm_in      = 1'b0;
        freeze      = 1'b0;
        val_rd      = 32'h0;
        mem_w_en_in = 1'b0;
        mem_r_en_in = 1'b0;
    endtask

    // Clock one edge, then drop s_in so status_out shows the registered flags.
    task automatic tick;
        @(posedge clk);
        #1;
        s_in = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        $display("[TB] test_reset");
        #3;
        checks++;
        if (alu_res_out !== 32'h0 || status_out !== 4'h0 || dest_out !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_init: res=%h status=%b dest=%h, expected 0", alu_res_out, status_out, dest_out);
        end
        @(negedge clk);
        rst = 1'b0;
        // Load non-zero state: 0x7FFFFFFF + 1 -> 0x80000000, NZCV 1001
        set_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1);
        dest_in = 4'h5; wb_en_in = 1'b1; mem_r_en_in = 1'b1;
        tick();
        checks++;
        if (alu_res_out !== 32'h8000_0000 || status_out !== 4'b1001 || dest_out !== 4'h5) begin
            errors++;
            $display("[TB] FAIL reset_preload: res=%h status=%b dest=%h, expected 80000000 1001 5", alu_res_out, status_out, dest_out);
        end
        // Mid-cycle reset while frozen, no clock edge in between
        freeze = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (alu_res_out !== 32'h0 || st_val_out !== 32'h0 || dest_out !== 4'h0 ||
            wb_en_out !== 1'b0 || mem_r_en_out !== 1'b0 || mem_w_en_out !== 1'b0 ||
            status_out !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_async: res=%h st=%h dest=%h ctrl=%b%b%b status=%b, expected all 0",
                     alu_res_out, st_val_out, dest_out, wb_en_out, mem_r_en_out, mem_w_en_out, status_out);
        end
        #1;
        rst = 1'b0;
        freeze = 1'b0;
        dest_in = 4'h0; wb_en_in = 1'b0; mem_r_en_in = 1'b0;
    endtask

    task automatic test_arith;
        $display("[TB] test_arith");
        set_op(4'b0010, 32'd5, 32'd3, 1'b1);
        tick();
        checks++;
        if (alu_res_out !== 32'd8 || status_out !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL add_5_3: res=%h status=%b, expected 8 0000", alu_res_out, status_out);
        end
        set_op(4'b0100, 32'd3, 32'd5, 1'b1);
        tick();
        checks++;
        if (alu_res_out !== 32'hFFFF_FFFE || status_out !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL sub_3_5: res=%h status=%b, expected fffffffe 1000", alu_res_out, status_out);
        end
        // C=0 from the subtraction above, so one extra is borrowed
        set_op(4'b0101, 32'd10, 32'd2, 1'b1);
        tick();
        checks++;
        if (alu_res_out !== 32'd7 || status_out !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL sbc_10_2: res=%h status=%b, expected 7 0010", alu_res_out, status_out);
        end
        // C=1 now, so ADC adds it in
        set_op(4'b0011, 32'd1, 32'd1, 1'b1);
        tick();
        checks++;
        if (alu_res_out !== 32'd3 || status_out !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL adc_1_1: res=%h status=%b, expected 3 0000", alu_res_out, status_out);
        end
        // Unsigned carry out without signed overflow
        set_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b1);
        tick();
        checks++;
        if (alu_res_out !== 32'h0 || status_out !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL add_carry: res=%h status=%b, expected 0 0110", alu_res_out, status_out);
        end
        // Signed overflow on subtraction: 0x80000000 - 1
        set_op(4'b0100, 32'h8000_0000, 32'd1, 1'b1);
        tick();
        checks++;
        if (alu_res_out !== 32'h7FFF_FFFF || status_out !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL sub_overflow: res=%h status=%b, expected 7fffffff 0011", alu_res_out, status_out);
        end
    endtask

    task automatic test_logic;
        $display("[TB] test_logic");
        set_op(4'b0100, 32'd5, 32'd3, 1'b1);
        tick();
        checks++;
        if (alu_res_out !== 32'd2 || status_out !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL sub_5_3: res=%h status=%b, expected 2 0010", alu_res_out, status_out);
        end
        // AND result zero; C kept at 1
        set_op(4'b0110, 32'hF0F0, 32'h0F0F, 1'b1);
        tick();
        checks++;
        if (alu_res_out !== 32'h0 || status_out !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL and_zero: res=%h status=%b, expected 0 0110", alu_res_out, status_out);
        end
        // ORR without S: flags hold
        set_op(4'b0111, 32'hF0F0, 32'h0F0F, 1'b0);
        tick();
        checks++;
        if (alu_res_out !== 32'hFFFF || status_out !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL orr_nos: res=%h status=%b, expected ffff 0110", alu_res_out, status_out);
        end
        set_op(4'b1000, 32'hFF00, 32'h0FF0, 1'b0);
        tick();
        checks++;
        if (alu_res_out !== 32'hF0F0) begin
            errors++;
            $display("[TB] FAIL eor: res=%h, expected f0f0", alu_res_out);
        end
        set_op(4'b1001, 32'h1234, 32'h0, 1'b1);
        tick();
        checks++;
        if (alu_res_out !== 32'hFFFF_FFFF || status_out !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL mvn: res=%h status=%b, expected ffffffff 1010", alu_res_out, status_out);
        end
        set_op(4'b0001, 32'hDEAD, 32'h1234, 1'b0);
        tick();
        checks++;
        if (alu_res_out !== 32'h1234) begin
            errors++;
            $display("[TB] FAIL mov: res=%h, expected 1234", alu_res_out);
        end
        // Undefined command: zero result, flags untouched even with S set
        set_op(4'b0000, 32'h55, 32'h66, 1'b1);
        tick();
        checks++;
        if (alu_res_out !== 32'h0 || status_out !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL bad_cmd: res=%h status=%b, expected 0 1010", alu_res_out, status_out);
        end
    endtask

    task automatic test_forward;
        $display("[TB] test_forward");
        set_op(4'b0010, 32'h0, 32'h1, 1'b0);
        sel_src1 = 2'b10; mem_alu_res = 32'h10; wb_value = 32'h20;
        tick();
        checks++;
        if (alu_res_out !== 32'h11) begin
            errors++;
            $display("[TB] FAIL fwd_mem_a: res=%h, expected 11", alu_res_out);
        end
        set_op(4'b0010, 32'h0, 32'h1, 1'b0);
        sel_src1 = 2'b01;
        tick();
        checks++;
        if (alu_res_out !== 32'h21) begin
            errors++;
            $display("[TB] FAIL fwd_wb_a: res=%h, expected 21", alu_res_out);
        end
        // Register operand B forwarded from MEM; store data follows it
        set_op(4'b0010, 32'h1, 32'h7, 1'b0);
        sel_src2 = 2'b10; mem_alu_res = 32'h100; val_rd = 32'h33;
        tick();
        checks++;
        if (alu_res_out !== 32'h101 || st_val_out !== 32'h100) begin
            errors++;
            $display("[TB] FAIL fwd_mem_b: res=%h st=%h, expected 101 100", alu_res_out, st_val_out);
        end
        // Code 11 on both selects means no forwarding
        set_op(4'b0010, 32'h2, 32'h7, 1'b0);
        sel_src1 = 2'b11; sel_src2 = 2'b11; val_rd = 32'h44;
        tick();
        checks++;
        if (alu_res_out !== 32'h9 || st_val_out !== 32'h44) begin
            errors++;
            $display("[TB] FAIL sel_11: res=%h st=%h, expected 9 44", alu_res_out, st_val_out);
        end
    endtask

    task automatic test_store;
        $display("[TB] test_store");
        set_op(4'b0010, 32'h1000, 32'h4, 1'b0);
        imm_in = 1'b1; sel_src2 = 2'b01; wb_value = 32'hABCD; val_rd = 32'h1;
        mem_w_en_in = 1'b1; wb_en_in = 1'b0; dest_in = 4'hA;
        tick();
        checks++;
        if (alu_res_out !== 32'h1004 || st_val_out !== 32'hABCD) begin
            errors++;
            $display("[TB] FAIL str_path: res=%h st=%h, expected 1004 abcd", alu_res_out, st_val_out);
        end
        checks++;
        if (mem_w_en_out !== 1'b1 || wb_en_out !== 1'b0 || mem_r_en_out !== 1'b0 || dest_out !== 4'hA) begin
            errors++;
            $display("[TB] FAIL str_ctrl: w=%b wb=%b r=%b dest=%h, expected 1 0 0 a",
                     mem_w_en_out, wb_en_out, mem_r_en_out, dest_out);
        end
    endtask

    task automatic test_freeze;
        $display("[TB] test_freeze");
        set_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1);
        dest_in = 4'h3; wb_en_in = 1'b1;
        tick();
        checks++;
        if (alu_res_out !== 32'h8000_0000 || status_out !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL add_ovf: res=%h status=%b, expected 80000000 1001", alu_res_out, status_out);
        end
        for (int i = 0; i < 3; i++) begin
            set_op(4'b0100, 32'd3, 32'd5, 1'b1);
            freeze = 1'b1; dest_in = 4'hC; wb_en_in = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (alu_res_out !== 32'h8000_0000 || status_out !== 4'b1001 ||
                dest_out !== 4'h3 || wb_en_out !== 1'b1) begin
                errors++;
                $display("[TB] FAIL freeze_hold[%0d]: res=%h status=%b dest=%h wb=%b, expected 80000000 1001 3 1",
                         i, alu_res_out, status_out, dest_out, wb_en_out);
            end
        end
        freeze = 1'b0;
        s_in = 1'b1;
        tick();
        checks++;
        if (alu_res_out !== 32'hFFFF_FFFE || status_out !== 4'b1000 || dest_out !== 4'hC) begin
            errors++;
            $display("[TB] FAIL unfreeze: res=%h status=%b dest=%h, expected fffffffe 1000 c", alu_res_out, status_out, dest_out);
        end
    endtask

    task automatic test_back_to_back;
        $display("[TB] test_back_to_back");
        set_op(4'b0010, 32'd20, 32'd22, 1'b0);
        tick();
        checks++;
        if (alu_res_out !== 32'd42) begin
            errors++;
            $display("[TB] FAIL b2b_first: res=%h, expected 2a", alu_res_out);
        end
        // Dependent op takes A from MEM (previous result now in MEM stage)
        set_op(4'b0100, 32'hDEAD, 32'd2, 1'b0);
        sel_src1 = 2'b10; mem_alu_res = 32'd42;
        tick();
        checks++;
        if (alu_res_out !== 32'd40) begin
            errors++;
            $display("[TB] FAIL b2b_second: res=%h, expected 28", alu_res_out);
        end
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; val_rn = '0; val2_in = '0; val_rd = '0;
        imm_in = 1'b0; sel_src1 = 2'b00; sel_src2 = 2'b00; wb_value = '0;
        mem_alu_res = '0; exe_cmd = 4'h0; s_in = 1'b0; dest_in = '0;
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        test_reset();
        test_arith();
        test_logic();
        test_forward();
        test_store();
        test_freeze();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
